// File: rtl/flag_stack.sv
// flag_stack: live condition flags for the running context plus a LIFO of
// saved flag sets, one entry per interrupt nesting level.
module flag_stack #(
  parameter int unsigned NFLAGS = 4,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned LW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [NFLAGS-1:0] flags_in,
  input  logic [NFLAGS-1:0] upd,
  input  logic              int_enter,
  input  logic              int_exit,
  output logic [NFLAGS-1:0] flags_out,
  output logic [LW-1:0]     level,
  output logic              in_handler,
  output logic              err
);

  logic [NFLAGS-1:0] cur_q, cur_d;
  logic [NFLAGS-1:0] stack_q [DEPTH];
  logic [NFLAGS-1:0] stack_d [DEPTH];
  logic [LW-1:0]     level_q, level_d;
  logic              err_q, err_d;

  logic push, pop, chain;
  logic at_full, at_empty;

  assign push     = int_enter & ~int_exit;
  assign pop      = int_exit & ~int_enter;
  assign chain    = int_enter & int_exit;
  assign at_full  = (level_q == LW'(DEPTH));
  assign at_empty = (level_q == '0);

  // Next-state: clr beats context events, which beat per-bit flag updates.
  always_comb begin
    cur_d   = cur_q;
    stack_d = stack_q;
    level_d = level_q;
    err_d   = err_q;
    if (clr) begin
      cur_d   = '0;
      level_d = '0;
      err_d   = 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stack_d[i] = '0;
      end
    end else if (chain) begin
      // Tail-chain: the next handler starts clean at the same depth.
      cur_d = '0;
    end else if (push) begin
      if (at_full) begin
        err_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (LW'(i) == level_q) begin
            stack_d[i] = cur_q;
          end
        end
        level_d = level_q + LW'(1);
        cur_d   = '0;
      end
    end else if (pop) begin
      if (at_empty) begin
        err_d = 1'b1;
      end else begin
        for (int unsigned i = 0; i < DEPTH; i++) begin
          if (LW'(i) == level_q - LW'(1)) begin
            cur_d      = stack_q[i];
            stack_d[i] = '0;
          end
        end
        level_d = level_q - LW'(1);
      end
    end else begin
      cur_d = (cur_q & ~upd) | (flags_in & upd);
    end
  end

  // State registers; reset discards every saved context.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_q   <= '0;
      level_q <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      cur_q   <= cur_d;
      level_q <= level_d;
      err_q   <= err_d;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        stack_q[i] <= stack_d[i];
      end
    end
  end

  assign flags_out  = cur_q;
  assign level      = level_q;
  assign in_handler = (level_q != '0);
  assign err        = err_q;

endmodule

// File: tb/tb_flag_stack.sv
// Directed bench for flag_stack with hand-computed expectations.
module tb_flag_stack;

  localparam int unsigned NFLAGS = 4;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned LW     = $clog2(DEPTH + 1);

  logic              clk;
  logic              rst;
  logic              clr;
  logic [NFLAGS-1:0] flags_in;
  logic [NFLAGS-1:0] upd;
  logic              int_enter;
  logic              int_exit;
  logic [NFLAGS-1:0] flags_out;
  logic [LW-1:0]     level;
  logic              in_handler;
  logic              err;

  int n_tests = 0;
  int n_fail  = 0;

  flag_stack #(
    .NFLAGS(NFLAGS),
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .flags_in  (flags_in),
    .upd       (upd),
    .int_enter (int_enter),
    .int_exit  (int_exit),
    .flags_out (flags_out),
    .level     (level),
    .in_handler(in_handler),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge, then settle so outputs are sampled off the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [3:0] f, input int lv,
                             input logic e);
    check({tag, ".flags"}, 32'(flags_out), 32'(f));
    check({tag, ".level"}, 32'(level), 32'(lv));
    check({tag, ".inh"}, 32'(in_handler), 32'(lv != 0));
    check({tag, ".err"}, 32'(err), 32'(e));
  endtask

  task automatic set_flags(input logic [3:0] f);
    flags_in = f;
    upd      = 4'b1111;
    step();
    upd      = 4'b0000;
  endtask

  task automatic enter();
    int_enter = 1'b1;
    step();
    int_enter = 1'b0;
  endtask

  task automatic leave();
    int_exit = 1'b1;
    step();
    int_exit = 1'b0;
  endtask

  initial begin
    rst = 1'b1; clr = 1'b0; flags_in = '0; upd = '0; int_enter = 1'b0; int_exit = 1'b0;
    #3;
    check_state("rst_async", 4'b0000, 0, 1'b0);
    step();
    check_state("rst_held", 4'b0000, 0, 1'b0);
    rst = 1'b0;

    // Per-bit update, then hold with upd=0.
    flags_in = 4'b1011; upd = 4'b0011;
    step();
    check("upd_partial", 32'(flags_out), 32'(4'b0011));
    upd = 4'b0000; flags_in = 4'b1100;
    step();
    check("upd_hold1", 32'(flags_out), 32'(4'b0011));
    flags_in = 4'b0110;
    step();
    check("upd_hold2", 32'(flags_out), 32'(4'b0011));

    // Nest and unwind.
    set_flags(4'b0101);
    check("user_flags", 32'(flags_out), 32'(4'b0101));
    flags_in = 4'b1111; upd = 4'b1111;  // must be ignored on push
    enter();
    upd = 4'b0000;
    check_state("nest_e1", 4'b0000, 1, 1'b0);
    set_flags(4'b1000);
    enter();
    check_state("nest_e2", 4'b0000, 2, 1'b0);
    leave();
    check_state("nest_x1", 4'b1000, 1, 1'b0);
    flags_in = 4'b0010; upd = 4'b1111;  // must be ignored on pop
    leave();
    upd = 4'b0000;
    check_state("nest_x2", 4'b0101, 0, 1'b0);

    // Overflow: four pushes fill the stack, the fifth is refused.
    set_flags(4'b0001); enter();
    set_flags(4'b0010); enter();
    set_flags(4'b0011); enter();
    set_flags(4'b0100); enter();
    check_state("ovf_full", 4'b0000, 4, 1'b0);
    set_flags(4'b0110);
    flags_in = 4'b1111; upd = 4'b1111;
    enter();
    upd = 4'b0000;
    check_state("ovf_e5", 4'b0110, 4, 1'b1);
    leave(); check_state("ovf_x1", 4'b0100, 3, 1'b1);
    leave(); check_state("ovf_x2", 4'b0011, 2, 1'b1);
    leave(); check_state("ovf_x3", 4'b0010, 1, 1'b1);
    leave(); check_state("ovf_x4", 4'b0001, 0, 1'b1);

    // Clear, then underflow, then clear again.
    clr = 1'b1; step(); clr = 1'b0;
    check_state("clr1", 4'b0000, 0, 1'b0);
    set_flags(4'b1010);
    flags_in = 4'b0101; upd = 4'b1111;
    leave();
    upd = 4'b0000;
    check_state("udf", 4'b1010, 0, 1'b1);
    clr = 1'b1; int_enter = 1'b1; flags_in = 4'b1111; upd = 4'b1111;
    step();
    clr = 1'b0; int_enter = 1'b0; upd = 4'b0000;
    check_state("clr2", 4'b0000, 0, 1'b0);

    // Tail-chain at level 2 with upd also asserted.
    set_flags(4'b0111); enter();
    set_flags(4'b1001); enter();
    set_flags(4'b1111);
    check_state("tc_pre", 4'b1111, 2, 1'b0);
    int_enter = 1'b1; int_exit = 1'b1; flags_in = 4'b1010; upd = 4'b1111;
    step();
    int_enter = 1'b0; int_exit = 1'b0; upd = 4'b0000;
    check_state("tc", 4'b0000, 2, 1'b0);
    leave();
    check_state("tc_x", 4'b1001, 1, 1'b0);

    // Asynchronous reset mid-nest at level 3.
    set_flags(4'b0011); enter();
    set_flags(4'b1100); enter();
    check_state("ar_pre", 4'b0000, 3, 1'b0);
    set_flags(4'b0110);
    #2 rst = 1'b1;
    #1;
    check_state("ar_async", 4'b0000, 0, 1'b0);
    step();
    check_state("ar_held", 4'b0000, 0, 1'b0);
    rst = 1'b0;
    leave();
    check_state("ar_udf", 4'b0000, 0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_stack.md
# flag_stack

Nested-context condition-flag register for the processor core, replacing the fixed two-bank (user/interrupt) flag unit. Holds the live flag set for the running context and a LIFO of saved flag sets, one per interrupt nesting level. Sits beside the ALU: ALU result flags and per-flag update enables come in, the live flags go out to branch logic, and interrupt entry/exit pulses from the control unit push and pop contexts.

## Interface
Parameters:
- NFLAGS, 4, number of flag bits; bit order [3]=C, [2]=N, [1]=OV, [0]=Z at default
- DEPTH, 4, maximum interrupt nesting levels (saved contexts); must be ≥1

Ports (clock and reset first):
- clk  in  1  core clock; all state changes on rising edge
- rst  in  1  reset, asynchronous, active-high
- clr  in  1  synchronous clear (core halted): zeroes live flags, stack, level and err
- flags_in  in  NFLAGS  ALU result flags
- upd  in  NFLAGS  per-bit update enable; flags[i] loads flags_in[i] when upd[i]=1
- int_enter  in  1  one-cycle pulse: enter interrupt handler (push)
- int_exit  in  1  one-cycle pulse: return from handler (pop)
- flags_out  out  NFLAGS  live flags of current context
- level  out  $clog2(DEPTH+1)  current nesting level; 0 = user mode
- in_handler  out  1  level != 0
- err  out  1  sticky: push at full depth or pop at level 0 attempted

## Operation
- State: live register cur[NFLAGS], stack[DEPTH][NFLAGS], level counter 0..DEPTH, sticky err.
- Per-cycle priority: rst > clr > (int_enter/int_exit) > upd.
- clr: cur=0, all stack entries=0, level=0, err=0.
- int_enter only, level<DEPTH: stack[level]<=cur; level<=level+1; cur<=0 (handler starts with clean flags). upd ignored that cycle.
- int_enter only, level==DEPTH: overflow; err<=1; cur, stack, level unchanged; upd ignored.
- int_exit only, level>0: cur<=stack[level-1]; stack[level-1]<=0; level<=level-1. upd ignored.
- int_exit only, level==0: underflow; err<=1; cur, level unchanged; upd ignored.
- int_enter and int_exit together (tail-chain): level and stack unchanged, cur<=0; upd ignored; err unchanged, including at level 0 or DEPTH.
- No event: cur[i]<=flags_in[i] where upd[i]=1, else hold. upd=0 holds all.
- Saved contexts are never modified except by push, pop and clr.
- err only clears on rst or clr.

## Timing
- Reset values: flags_out=0, level=0, in_handler=0, err=0; all stack entries 0.
- rst asynchronous: outputs go to reset values immediately on assertion, independent of clk; registers stay cleared while rst high.
- flags_out, level, in_handler, err are driven directly from registers; no combinational path from any input to any output.
- Update latency: 1 cycle (flags_in sampled at edge N, visible after edge N).
- Push/pop latency: 1 cycle; the restored or cleared flags and the new level appear together after the same edge.
- Back-to-back events are legal every cycle: enter,enter,exit,exit returns to the original user flags in 4 cycles.
- rst mid-nest discards all saved contexts. No recovery of the stack is provided.

## Test plan
- Reset/update: assert rst, check all outputs 0. Release, flags_in=4'b1011, upd=4'b0011 -> next cycle flags_out=4'b0011; then upd=0 with flags_in changing -> flags_out holds 4'b0011.
- Nest and unwind: user flags 4'b0101; enter -> flags_out=0, level=1; update to 4'b1000; enter -> 0, level=2; exit -> 4'b1000, level=1; exit -> 4'b0101, level=0, in_handler=0.
- Overflow: DEPTH=4, five enters with distinct flags set between them -> fifth leaves level=4, err=1; four exits restore each saved set in reverse order.
- Underflow and clear: exit at level 0 -> err=1, flags unchanged; clr -> err=0, flags_out=0, level=0.
- Tail-chain and priority: at level 2 with cur=4'b1111, assert int_enter+int_exit+upd together -> level=2, flags_out=0; an exit then restores the level-1 saved flags.
- Async reset mid-nest: at level 3, pulse rst between clock edges -> outputs 0 immediately; an exit after release sets err=1.
